// File: rtl/sprite_ram_arbiter.sv
// Round-robin arbiter sharing one sprite RAM read port among NUM_REQ requesters; responses tagged by id.
// Optional write port enabled by defining SPRITE_WRITE_EN.
module sprite_ram_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 24,
  parameter int DEPTH   = 870,
  parameter int RAM_LAT = 1
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         ram_read_address,
  input  logic [DATA_W-1:0]         ram_data_out,
  output logic                      rsp_valid,
  output logic [2:0]                rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_write_address,
  output logic [DATA_W-1:0]         ram_data_in
`ifdef SPRITE_WRITE_EN
  ,
  input  logic                      wr_req,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      wr_ack
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  rr_next;
  logic              arb_en;
  logic              wr_block;
  logic              grant_any;
  logic [2:0]        win_id;
  logic [ADDR_W-1:0] win_addr;
  logic              win_in_range;
  int unsigned       idx;

  logic [RAM_LAT-1:0] v_sr;
  logic [RAM_LAT-1:0] e_sr;
  logic [2:0]         id_sr [RAM_LAT];

`ifdef SPRITE_WRITE_EN
  logic wr_in_range;
  assign wr_in_range       = ({1'b0, wr_addr} < DEPTH_V);
  assign wr_block          = wr_req;
  assign wr_ack            = wr_req;
  assign ram_we            = wr_req && wr_in_range;
  assign ram_write_address = wr_req ? wr_addr : '0;
  assign ram_data_in       = wr_req ? wr_data : '0;
`else
  assign wr_block          = 1'b0;
  assign ram_we            = 1'b0;
  assign ram_write_address = '0;
  assign ram_data_in       = '0;
`endif

  // Grant is suppressed while reset is held so requesters never see a grant that is discarded.
  assign arb_en = Reset_n && !wr_block;

  always_comb begin
    gnt       = '0;
    grant_any = 1'b0;
    win_id    = '0;
    win_addr  = '0;
    rr_next   = rr_ptr;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (arb_en && !grant_any && req[idx[PTR_W-1:0]]) begin
        grant_any            = 1'b1;
        gnt[idx[PTR_W-1:0]]  = 1'b1;
        win_id               = 3'(idx);
        win_addr             = req_addr[idx*ADDR_W +: ADDR_W];
        rr_next              = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  assign win_in_range     = ({1'b0, win_addr} < DEPTH_V);
  assign ram_read_address = (grant_any && win_in_range) ? win_addr : '0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr <= '0;
      v_sr   <= '0;
      e_sr   <= '0;
      for (int unsigned i = 0; i < RAM_LAT; i++) id_sr[i] <= '0;
    end else begin
      rr_ptr   <= rr_next;
      v_sr[0]  <= grant_any;
      e_sr[0]  <= grant_any && !win_in_range;
      id_sr[0] <= win_id;
      for (int unsigned i = 1; i < RAM_LAT; i++) begin
        v_sr[i]  <= v_sr[i-1];
        e_sr[i]  <= e_sr[i-1];
        id_sr[i] <= id_sr[i-1];
      end
    end
  end

  assign rsp_valid = v_sr[RAM_LAT-1];
  assign rsp_err   = e_sr[RAM_LAT-1];
  assign rsp_id    = id_sr[RAM_LAT-1];
  assign rsp_data  = (rsp_valid && !rsp_err) ? ram_data_out : '0;

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Table-driven bench for sprite_ram_arbiter with a response scoreboard and a bench-side RAM model.
module tb_sprite_ram_arbiter;
  localparam int N = 3, AW = 10, DW = 24, DEPTH = 870, LAT = 1;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic [N-1:0]  req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  gnt;
  logic [AW-1:0] ram_read_address;
  logic [DW-1:0] ram_data_out;
  logic          rsp_valid;
  logic [2:0]    rsp_id;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          ram_we;
  logic [AW-1:0] ram_write_address;
  logic [DW-1:0] ram_data_in;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
`ifdef SPRITE_WRITE_EN
  logic          wr_ack;
`endif

  always #5 Clk = ~Clk;

  sprite_ram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RAM_LAT(LAT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .req_addr(req_addr), .gnt(gnt),
    .ram_read_address(ram_read_address), .ram_data_out(ram_data_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ram_we(ram_we), .ram_write_address(ram_write_address), .ram_data_in(ram_data_in)
`ifdef SPRITE_WRITE_EN
    , .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack)
`endif
  );

  // Environment RAM: registered read, driven by the DUT's RAM ports.
  logic [DW-1:0] mem     [1024];
  logic [DW-1:0] ref_mem [1024];
  always @(posedge Clk) begin
    if (ram_we) mem[ram_write_address] <= ram_data_in;
    ram_data_out <= mem[ram_read_address];
  end

  typedef struct {
    logic [2:0]  req;
    logic [9:0]  a0, a1, a2;
    logic [2:0]  gnt;
  } vec_t;

  typedef struct {
    int unsigned due;
    logic [2:0]  id;
    logic [23:0] data;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  vec_t        vecs[17];
  int unsigned cyc;
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step(input logic [2:0] r, input logic [9:0] a0, input logic [9:0] a1,
                      input logic [9:0] a2, input logic [2:0] eg);
    int         id;
    logic [9:0] sel;
    logic [9:0] ea;
    exp_t       e;
    req      = r;
    req_addr = {a2, a1, a0};
    #1;
    chk("gnt", 32'(gnt), 32'(eg));
    id  = (eg == 3'b001) ? 0 : (eg == 3'b010) ? 1 : (eg == 3'b100) ? 2 : -1;
    sel = (id == 0) ? a0 : (id == 1) ? a1 : a2;
    ea  = (id >= 0 && int'(sel) < DEPTH) ? sel : 10'd0;
    chk("ram_read_address", 32'(ram_read_address), 32'(ea));
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(e.id));
      chk("rsp_data", 32'(rsp_data), 32'(e.data));
      chk("rsp_err", 32'(rsp_err), 32'(e.err));
    end else begin
      chk("rsp_idle", 32'({rsp_valid, rsp_id, rsp_err, rsp_data}), 32'd0);
    end
`ifdef SPRITE_WRITE_EN
    chk("wr_ack", 32'(wr_ack), 32'(wr_req));
    chk("ram_we", 32'(ram_we), 32'(wr_req && int'(wr_addr) < DEPTH));
    if (wr_req && int'(wr_addr) < DEPTH) begin
      chk("ram_write_address", 32'(ram_write_address), 32'(wr_addr));
      chk("ram_data_in", 32'(ram_data_in), 32'(wr_data));
    end
`else
    chk("wr_port_idle", 32'({ram_we, ram_write_address, ram_data_in}) | 32'(ram_write_address), 32'd0);
`endif
    if (id >= 0) begin
      e.due  = cyc + LAT;
      e.id   = 3'(id);
      e.err  = (int'(sel) >= DEPTH);
      e.data = e.err ? 24'd0 : ref_mem[sel];
      sbq.push_back(e);
    end
    @(posedge Clk);
    if (wr_req && int'(wr_addr) < DEPTH) ref_mem[wr_addr] = wr_data;
    cyc++;
    @(negedge Clk);
  endtask

  initial begin
    Reset_n  = 1'b0;
    req      = '0;
    req_addr = '0;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    cyc      = 0;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 24'(i * 40503 + 24'h13579B);
      mem[i]     = ref_mem[i];
    end
    ref_mem[25] = 24'hFF00FF;
    mem[25]     = 24'hFF00FF;

    //           req     a0   a1    a2    gnt
    vecs[0]  = '{3'b111, 10,  20,   30,   3'b001};
    vecs[1]  = '{3'b111, 11,  21,   31,   3'b010};
    vecs[2]  = '{3'b111, 12,  22,   32,   3'b100};
    vecs[3]  = '{3'b111, 13,  23,   33,   3'b001};
    vecs[4]  = '{3'b111, 14,  24,   34,   3'b010};
    vecs[5]  = '{3'b111, 15,  25,   35,   3'b100};
    vecs[6]  = '{3'b010, 0,   25,   0,    3'b010};
    vecs[7]  = '{3'b000, 0,   0,    0,    3'b000};
    vecs[8]  = '{3'b011, 40,  41,   0,    3'b001};
    vecs[9]  = '{3'b011, 42,  43,   0,    3'b010};
    vecs[10] = '{3'b001, 44,  0,    0,    3'b001};
    vecs[11] = '{3'b100, 0,   0,    870,  3'b100};
    vecs[12] = '{3'b001, 869, 0,    0,    3'b001};
    vecs[13] = '{3'b110, 0,   1023, 50,   3'b010};
    vecs[14] = '{3'b101, 51,  0,    52,   3'b100};
    vecs[15] = '{3'b110, 0,   53,   54,   3'b010};
    vecs[16] = '{3'b000, 0,   0,    0,    3'b000};

    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Reset with one read in flight: response dropped, grants held off, rr_ptr back to 0.
    step(3'b001, 5, 0, 0, 3'b001);
    Reset_n = 1'b0;
    req     = 3'b111;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    sbq.delete();
    @(posedge Clk);
    @(negedge Clk);
    #1;
    chk("rst_rsp_valid_hold", 32'(rsp_valid), 32'd0);
    chk("rst_gnt_hold", 32'(gnt), 32'd0);
    req     = '0;
    Reset_n = 1'b1;
    @(negedge Clk);

    foreach (vecs[i]) step(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].gnt);

`ifdef SPRITE_WRITE_EN
    // rr_ptr is 2 here; a write cycle must not move it.
    wr_req = 1'b1; wr_addr = 10'd25; wr_data = 24'h123456;
    step(3'b111, 1, 2, 3, 3'b000);
    wr_req = 1'b0;
    step(3'b111, 4, 5, 25, 3'b100);
    wr_req = 1'b1; wr_addr = 10'd900; wr_data = 24'hAAAAAA;
    step(3'b010, 0, 6, 0, 3'b000);
    wr_req = 1'b0;
    step(3'b000, 0, 0, 0, 3'b000);
`endif

    step(3'b000, 0, 0, 0, 3'b000);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
